// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    // Receive FSM states: wait for start bit, shift data, take parity, take stop.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int BITS_PER_BYTE = 8;

    // PS/2 frames use odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous scancode FIFO. Head entry is visible combinationally on dout
// and reads as zero when the FIFO is empty.
module ps2_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array: written on accepted pushes only.
    // NOTE: the memory has no reset; stale entries are never visible because
    // dout is masked by empty and the pointers/count are reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the raw pins, deframes 11-bit device
// frames, queues good scancodes and raises a level IRQ while data is pending.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd,
    input  logic       err_clr,
    output logic [7:0] kbd_data,
    output logic       kbd_ready,
    output logic       kbd_irq,
    output logic       err_frame,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic            clk_meta, clk_sync, clk_prev;
    logic            dat_meta, dat_sync;
    logic            fall;

    ps2_state_e      state, state_next;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic [TW-1:0]   to_cnt;
    logic            timeout_hit;

    logic            shift_en;
    logic            par_cap;
    logic            frame_end;
    logic            frame_good;
    logic            res_good;
    logic            res_bad;

    logic            fifo_empty;
    logic            fifo_full;
    logic            ovf_set;

    // Two-flop synchronisers per pin plus one history flop on the clock pin.
    // Preset to 1 so reset looks like an idle bus and cannot fake an edge.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking assignments here would collapse the synchroniser chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    assign fall        = clk_prev & ~clk_sync;
    assign timeout_hit = (to_cnt == TW'(TIMEOUT));

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and per-edge control strobes; advances only on PS/2 falling edges.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        par_cap    = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !dat_sync) state_next = DATA;
            end
            DATA: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'(BITS_PER_BYTE - 1)) state_next = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_cap    = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A stalled frame is abandoned silently.
        if (state != IDLE && !fall && timeout_hit) state_next = IDLE;
    end

    assign frame_good = dat_sync & odd_parity_ok(shift_reg, parity_bit);

    // Data path: bit counter, LSB-first shift register and parity capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (state == IDLE && fall) bit_cnt <= '0;
            else if (shift_en)         bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift_reg  <= {dat_sync, shift_reg[7:1]};
            if (par_cap)  parity_bit <= dat_sync;
        end
    end

    // Inactivity counter: cleared on each falling edge, parked at 0 in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                     to_cnt <= '0;
        else if (state == IDLE || fall) to_cnt <= '0;
        else if (!timeout_hit)         to_cnt <= to_cnt + 1'b1;
    end

    // Frame verdict registered on the STOP edge and acted on the following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_good <= 1'b0;
            res_bad  <= 1'b0;
        end else begin
            res_good <= frame_end & frame_good;
            res_bad  <= frame_end & ~frame_good;
        end
    end

    // shift_reg is stable during the result cycle: the next frame needs a
    // start edge before any further shifting.
    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BITS_PER_BYTE)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (res_good),
        .pop   (rd),
        .din   (shift_reg),
        .dout  (kbd_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A full FIFO only drops the frame when no pop frees a slot in the same cycle.
    assign ovf_set = res_good & fifo_full & ~rd;

    // Sticky error flags; a set event beats a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_frame <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            err_frame <= res_bad | (err_frame & ~err_clr);
            overflow  <= ovf_set | (overflow & ~err_clr);
        end
    end

    assign kbd_ready = ~fifo_empty;
    assign kbd_irq   = kbd_ready;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus randomized
// frames compared against a queue-based reference model.
module tb_ps2_keyboard;

    localparam int DEPTH = 16;
    localparam int HALF  = 20;   // system clocks per PS/2 half bit period

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd      = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_irq;
    logic       err_frame;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: queued scancodes and sticky flags.
    logic [7:0] exp_q[$];
    logic       exp_err = 1'b0;
    logic       exp_ovf = 1'b0;

    ps2_keyboard #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (2500)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rd        (rd),
        .err_clr   (err_clr),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .kbd_irq   (kbd_irq),
        .err_frame (err_frame),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    // Observed outputs packed as {irq, ready, err_frame, overflow, data}.
    function automatic logic [11:0] obs_vec();
        return {kbd_irq, kbd_ready, err_frame, overflow, kbd_data};
    endfunction

    // Expected outputs derived from the model queue and flags.
    function automatic logic [11:0] exp_vec();
        logic       nonempty;
        logic [7:0] head;
        nonempty = (exp_q.size() != 0);
        head     = nonempty ? exp_q[0] : 8'h00;
        return {nonempty, nonempty, exp_err, exp_ovf, head};
    endfunction

    // 11-bit frame, index 0 sent first: start, data LSB first, parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par_err,
                                               input logic stop_v);
        return {stop_v, (~^d) ^ par_err, d, 1'b0};
    endfunction

    // Drive n bits on the pins. strobe 1/2 pulses rd/err_clr for one clock
    // exactly in the result cycle of the last falling edge (2 sync flops + verdict).
    task automatic send_bits(input logic [10:0] bits, input int n, input int strobe);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clock);
                if (i == n - 1 && strobe != 0) begin
                    if (c == 3) begin
                        if (strobe == 1) rd = 1'b1; else err_clr = 1'b1;
                    end else if (c == 4) begin
                        rd      = 1'b0;
                        err_clr = 1'b0;
                    end
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    // Send a whole frame and advance the model by the frame rules.
    task automatic send_frame(input logic [7:0] d, input logic par_err, input logic stop_v,
                              input int strobe);
        send_bits(frame_bits(d, par_err, stop_v), 11, strobe);
        if (strobe == 1 && exp_q.size() != 0) void'(exp_q.pop_front());
        if (strobe == 2) begin
            exp_err = 1'b0;
            exp_ovf = 1'b0;
        end
        if (stop_v && !par_err) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else                      exp_ovf = 1'b1;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic do_read();
        @(negedge clock); rd = 1'b1;
        @(negedge clock); rd = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clock);
    endtask

    task automatic do_clr();
        @(negedge clock); err_clr = 1'b1;
        @(negedge clock); err_clr = 1'b0;
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (obs_vec() !== 12'h000) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", obs_vec(), 12'h000);
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_released got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        checks++;
        if (obs_vec() !== {4'b1100, 8'h1C}) begin
            failures++;
            $display("FAIL single_rx got=%h exp=%h", obs_vec(), {4'b1100, 8'h1C});
        end
        do_read();
        checks++;
        if (obs_vec() !== 12'h000) begin
            failures++;
            $display("FAIL single_pop got=%h exp=%h", obs_vec(), 12'h000);
        end
    endtask

    task automatic test_two();
        logic [7:0] expect_seq [3];
        expect_seq[0] = 8'hF0;
        expect_seq[1] = 8'h1C;
        expect_seq[2] = 8'h00;
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (kbd_data !== expect_seq[i] || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL two_frames[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            do_read();
        end
        // Third read was on an empty FIFO and must be ignored.
        checks++;
        if (obs_vec() !== 12'h000) begin
            failures++;
            $display("FAIL read_on_empty got=%h exp=%h", obs_vec(), 12'h000);
        end
    endtask

    task automatic test_errors();
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        checks++;
        if (obs_vec() !== {4'b0010, 8'h00}) begin
            failures++;
            $display("FAIL parity_err got=%h exp=%h", obs_vec(), {4'b0010, 8'h00});
        end
        do_clr();
        checks++;
        if (err_frame !== 1'b0) begin
            failures++;
            $display("FAIL err_clr got=%b exp=0", err_frame);
        end
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        checks++;
        if (obs_vec() !== {4'b0010, 8'h00}) begin
            failures++;
            $display("FAIL stop_err got=%h exp=%h", obs_vec(), {4'b0010, 8'h00});
        end
        // Clear in the same cycle as a new error: set wins.
        send_frame(8'h3A, 1'b1, 1'b1, 2);
        checks++;
        if (err_frame !== 1'b1 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL clr_vs_set got=%h exp=%h", obs_vec(), exp_vec());
        end
        do_clr();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 0);
            if (i == 16) begin
                checks++;
                if (overflow !== 1'b0 || kbd_data !== 8'h01) begin
                    failures++;
                    $display("FAIL fill_16 got=%h exp=%h", obs_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (obs_vec() !== {4'b1101, 8'h01}) begin
            failures++;
            $display("FAIL overflow got=%h exp=%h", obs_vec(), {4'b1101, 8'h01});
        end
        // Push on full with a simultaneous pop: both happen.
        send_frame(8'h12, 1'b0, 1'b1, 1);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (kbd_data !== exp_q[0] || kbd_ready !== 1'b1) begin
                failures++;
                $display("FAIL drain[%0d] got=%h exp=%h", i, kbd_data, exp_q[0]);
            end
            do_read();
        end
        checks++;
        if (obs_vec() !== {4'b0001, 8'h00}) begin
            failures++;
            $display("FAIL drain_empty got=%h exp=%h", obs_vec(), {4'b0001, 8'h00});
        end
        do_clr();
    endtask

    task automatic test_timeout();
        send_bits(frame_bits(8'hA5, 1'b0, 1'b1), 5, 0);
        repeat (2600) @(negedge clock);
        checks++;
        if (obs_vec() !== 12'h000) begin
            failures++;
            $display("FAIL timeout_idle got=%h exp=%h", obs_vec(), 12'h000);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        checks++;
        if (obs_vec() !== {4'b1100, 8'h5A}) begin
            failures++;
            $display("FAIL after_timeout got=%h exp=%h", obs_vec(), {4'b1100, 8'h5A});
        end
        do_read();
    endtask

    task automatic test_reset_mid();
        send_frame(8'h33, 1'b0, 1'b1, 0);
        send_frame(8'h44, 1'b1, 1'b1, 0);
        send_bits(frame_bits(8'hC3, 1'b0, 1'b1), 5, 0);
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (obs_vec() !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 12'h000);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        send_frame(8'h29, 1'b0, 1'b1, 0);
        checks++;
        if (obs_vec() !== {4'b1100, 8'h29}) begin
            failures++;
            $display("FAIL post_reset_rx got=%h exp=%h", obs_vec(), {4'b1100, 8'h29});
        end
        do_read();
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic [7:0] d;
            int         kind;
            int         strobe;
            int         nreads;
            d      = 8'($urandom);
            kind   = $urandom_range(0, 9);
            strobe = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            send_frame(d, kind == 0, kind != 1, strobe);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_frame[%0d] got=%h exp=%h", it, obs_vec(), exp_vec());
            end
            nreads = $urandom_range(0, 2);
            for (int r = 0; r < nreads; r++) do_read();
            if ($urandom_range(0, 5) == 0) do_clr();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_after_rd[%0d] got=%h exp=%h", it, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_errors();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
